stack_arbiter: RTL and testbench
================================

# stack_arbiter

Shares the single coordinate stack (4-bit x/y entries, push/pop strobes, fail flag) between two requesters: the maze explorer and the path dumper. It arbitrates round-robin, drives the stack strobes for exactly one cycle per transaction, and returns popped coordinates or an error through a req/ack handshake. It also mirrors stack occupancy so that over- and under-flow are rejected before the stack is touched.

## Interface
Parameters:
- W, 4, coordinate width; matches the stack x/y width.
- DEPTH, 16, stack capacity in entries; must equal the stack instance's depth.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  2  per-requester request level; index 0 is the explorer, index 1 is the dumper.
- op  in  2  per-requester operation: 0 = push, 1 = pop.
- wx  in  2×W  per-requester push x data.
- wy  in  2×W  per-requester push y data.
- ack  out  2  one-cycle completion pulse per requester.
- rx  out  W  popped x; valid while any ack bit is high.
- ry  out  W  popped y; valid while any ack bit is high.
- err  out  1  transaction failed; valid while any ack bit is high.
- count  out  $clog2(DEPTH+1)  mirrored occupancy.
- full, empty  out  1 each  count==DEPTH, count==0.
- stk_push, stk_pop  out  1 each  stack strobes.
- stk_x, stk_y  out  W each  stack data in.
- stk_xo, stk_yo  in  W each  stack top after a pop.
- stk_fail  in  1  stack error flag.

## Operation
- FSM states: IDLE, ISSUE, CAPT.
- IDLE:
  - A requester is eligible if its req is high and its ack is low.
  - If no requester is eligible, stay in IDLE.
  - If one is eligible, latch sel, op, and data, then go to ISSUE.
  - If both are eligible, grant the one that is not last_served.
- ISSUE, one cycle:
  - Compute rej = (push & full) | (pop & empty).
  - If rej is low, assert stk_push or stk_pop for this cycle only, with stk_x/stk_y = latched data.
  - If rej is high, assert no strobe.
  - Go to CAPT.
- CAPT, one cycle. At the exit edge:
  - ack[sel] <= 1.
  - err <= rej | stk_fail.
  - rx/ry <= stk_xo/stk_yo on a pop; rx/ry hold on a push.
  - If err is 0: count +1 on push, -1 on pop. If err is 1, count is unchanged.
  - last_served <= sel; go to IDLE.
- ack, rx, ry, and err are registered. ack clears after one cycle.
- Requesters hold req, op, and data stable until ack, and may re-request on the cycle after ack.
- stk_x/stk_y are 0 whenever not in ISSUE.
- The stack shares rst, so both sides clear together.

## Timing
- Reset values:
  - state = IDLE, ack = 0, err = 0, rx = ry = 0, count = 0, full = 0, empty = 1.
  - stk_push = stk_pop = 0, last_served = 1, so requester 0 wins first.
- Latency: req sampled at edge E0 → stack strobe in (E0,E1) → stack updates at E1 → ack high in (E2,E3).
  - This is fixed at 2 edges for every transaction, including rejected ones.
- Throughput: one transaction per 3 cycles. A requester that re-requests right after its ack gets its next grant at the edge following the ack cycle.
- Simultaneous requests:
  - Strict alternation while both stay high.
  - The losing requester is served immediately after the winner's CAPT, with no idle cycle.
- Boundaries:
  - Push at count==DEPTH → err, no strobe.
  - Pop at count==0 → err, no strobe, rx/ry unchanged.
  - Unexpected stk_fail → err, count held.
- A req that drops before ack is a protocol violation. The transaction still completes and ack is still issued.
- Reset mid-transaction (any state) immediately forces the reset values. The pending request is lost and no ack is issued.

## Structure
- Package stack_arb_pkg holds:
  - State enum {IDLE, ISSUE, CAPT}.
  - OP_PUSH = 0, OP_POP = 1.
  - Requester indices EXPLORER = 0, DUMPER = 1.
- Sub-module rr_arb2: a two-way round-robin picker, combinational.
  - Inputs: eligible[1:0], last_served.
  - Outputs: gnt_valid, gnt_idx.
  - last_served is registered in the parent.
- Estimated size: 150–250 lines of RTL including rr_arb2.

## Test plan
- Reset, then requester 0 pushes (x=1, y=0) → stk_push pulses once with 1/0; ack[0] arrives 2 edges after sampling; err=0; count=1.
- Then requester 1 pops → ack[1] with rx=1, ry=0, err=0; count=0, empty=1.
- Pop on an empty stack → no stk_pop strobe; ack with err=1; count stays 0; rx/ry unchanged.
- Push DEPTH times, then push (x=F, y=F) → ack with err=1 and no strobe; full=1; a following pop returns the last stored entry.
- Both req high continuously, both pushing → grants alternate 0,1,0,1; each ack spaced 3 cycles apart; stack holds the entries in grant order.
- Assert rst low while in ISSUE → all outputs return to reset values immediately; no ack; after release, requester 0 is granted first.

Source files
------------

// File: rtl/stack_arb_pkg.sv
// Shared types and constants for the coordinate-stack arbiter.
// Covers FSM states, operation encodings and requester indices.
package stack_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    CAPT  = 2'd2
  } state_t;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam int EXPLORER = 0;
  localparam int DUMPER   = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker, purely combinational.
// When both requesters are eligible, the one not served last wins.
module rr_arb2 (
  input  logic [1:0] eligible,
  input  logic       last_served,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  assign gnt_valid = |eligible;

  always_comb begin
    gnt_idx = 1'b0;
    case (eligible)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_served;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/stack_arbiter.sv
// Shares one coordinate stack between the explorer and the path dumper.
// Mirrors occupancy so over/underflow are rejected without strobing the stack.
module stack_arbiter
  import stack_arb_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req,
  input  logic [1:0]                 op,
  input  logic [2*W-1:0]             wx,
  input  logic [2*W-1:0]             wy,
  output logic [1:0]                 ack,
  output logic [W-1:0]               rx,
  output logic [W-1:0]               ry,
  output logic                       err,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       stk_push,
  output logic                       stk_pop,
  output logic [W-1:0]               stk_x,
  output logic [W-1:0]               stk_y,
  input  logic [W-1:0]               stk_xo,
  input  logic [W-1:0]               stk_yo,
  input  logic                       stk_fail
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  state_t     state;
  logic       sel;
  logic       op_q;
  logic       rej_q;
  logic       last_served;

  logic [1:0]   eligible;
  logic         gnt_valid;
  logic         gnt_idx;
  logic         cand_op;
  logic [W-1:0] cand_x;
  logic [W-1:0] cand_y;
  logic         cand_rej;

  // A requester still seeing its ack is masked so a held req is not re-served.
  assign eligible = req & ~ack;

  rr_arb2 u_rr (
    .eligible    (eligible),
    .last_served (last_served),
    .gnt_valid   (gnt_valid),
    .gnt_idx     (gnt_idx)
  );

  assign cand_op  = op[gnt_idx];
  assign cand_x   = gnt_idx ? wx[2*W-1:W] : wx[W-1:0];
  assign cand_y   = gnt_idx ? wy[2*W-1:W] : wy[W-1:0];
  assign full     = (count == DEPTH_C);
  assign empty    = (count == '0);
  // Count only moves at CAPT exit, so rejection can be decided at grant time.
  assign cand_rej = ((cand_op == OP_PUSH) && full) || ((cand_op == OP_POP) && empty);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      sel         <= 1'b0;
      op_q        <= OP_PUSH;
      rej_q       <= 1'b0;
      last_served <= 1'b1;
      ack         <= 2'b00;
      err         <= 1'b0;
      rx          <= '0;
      ry          <= '0;
      count       <= '0;
      stk_push    <= 1'b0;
      stk_pop     <= 1'b0;
      stk_x       <= '0;
      stk_y       <= '0;
    end else begin
      ack <= 2'b00;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            sel      <= gnt_idx;
            op_q     <= cand_op;
            rej_q    <= cand_rej;
            stk_push <= !cand_rej && (cand_op == OP_PUSH);
            stk_pop  <= !cand_rej && (cand_op == OP_POP);
            stk_x    <= cand_x;
            stk_y    <= cand_y;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          stk_push <= 1'b0;
          stk_pop  <= 1'b0;
          stk_x    <= '0;
          stk_y    <= '0;
          state    <= CAPT;
        end
        CAPT: begin
          ack[sel] <= 1'b1;
          err      <= rej_q | stk_fail;
          if ((op_q == OP_POP) && !rej_q) begin
            rx <= stk_xo;
            ry <= stk_yo;
          end
          if (!(rej_q | stk_fail)) begin
            if (op_q == OP_PUSH) count <= count + ONE_C;
            else                 count <= count - ONE_C;
          end
          last_served <= sel;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a behavioural coordinate stack attached.
module tb_stack_arbiter;

  localparam int W     = 4;
  localparam int DEPTH = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req;
  logic [1:0]     op;
  logic [2*W-1:0] wx;
  logic [2*W-1:0] wy;
  logic [1:0]     ack;
  logic [W-1:0]   rx;
  logic [W-1:0]   ry;
  logic           err;
  logic [4:0]     count;
  logic           full;
  logic           empty;
  logic           stk_push;
  logic           stk_pop;
  logic [W-1:0]   stk_x;
  logic [W-1:0]   stk_y;
  logic [W-1:0]   stk_xo;
  logic [W-1:0]   stk_yo;
  logic           stk_fail;
  logic           fail_inject;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] sx, sy;
  int lat, npush, npop;

  stack_arbiter #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .wx(wx), .wy(wy),
    .ack(ack), .rx(rx), .ry(ry), .err(err), .count(count),
    .full(full), .empty(empty), .stk_push(stk_push), .stk_pop(stk_pop),
    .stk_x(stk_x), .stk_y(stk_y), .stk_xo(stk_xo), .stk_yo(stk_yo),
    .stk_fail(stk_fail)
  );

  always #5 clk = ~clk;

  // Behavioural stack sharing the arbiter reset.
  logic [2*W-1:0] mem [DEPTH];
  int sp;
  assign stk_fail = fail_inject;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp     <= 0;
      stk_xo <= '0;
      stk_yo <= '0;
    end else if (stk_push && sp < DEPTH) begin
      mem[sp] <= {stk_x, stk_y};
      sp      <= sp + 1;
    end else if (stk_pop && sp > 0) begin
      {stk_xo, stk_yo} <= mem[sp-1];
      sp <= sp - 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction from requester idx; returns edges-to-ack and strobe counts.
  task automatic txn(input int idx, input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    while (ack != 2'b00) @(negedge clk);
    req[idx] = 1'b1;
    op[idx]  = o;
    wx[idx*W +: W] = x;
    wy[idx*W +: W] = y;
    lat = 0; npush = 0; npop = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (stk_push) begin npush++; sx = stk_x; sy = stk_y; end
      if (stk_pop) npop++;
      if (ack[idx]) break;
    end
    req[idx] = 1'b0;
    chk("ack_seen", {31'd0, ack[idx]}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ack_idx [4];
    int ack_cyc [4];
    int n, cyc, ack_cnt;

    rst = 1'b0; req = 2'b00; op = 2'b00; wx = '0; wy = '0; fail_inject = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    chk("rst_ack", {30'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rxry", {24'd0, rx, ry}, 32'd0);
    chk("rst_count", {27'd0, count}, 32'd0);
    chk("rst_full_empty", {30'd0, full, empty}, 32'd1);
    chk("rst_strobes", {22'd0, stk_push, stk_pop, stk_x, stk_y}, 32'd0);

    // Explorer pushes (1,0).
    txn(0, 1'b0, 4'd1, 4'd0);
    chk("push1_latency", lat, 3);
    chk("push1_strobes", npush, 1);
    chk("push1_data", {24'd0, sx, sy}, 32'h10);
    chk("push1_err", {31'd0, err}, 32'd0);
    chk("push1_count", {27'd0, count}, 32'd1);
    @(posedge clk); #1;
    chk("ack_one_cycle", {30'd0, ack}, 32'd0);

    // Dumper pops it back.
    txn(1, 1'b1, 4'd0, 4'd0);
    chk("pop1_strobes", npop, 1);
    chk("pop1_rxry", {24'd0, rx, ry}, 32'h10);
    chk("pop1_err", {31'd0, err}, 32'd0);
    chk("pop1_count_empty", {26'd0, count, empty}, 32'd1);

    // Underflow: rejected without strobe, rx/ry held at (1,0).
    txn(0, 1'b1, 4'd0, 4'd0);
    chk("uflow_latency", lat, 3);
    chk("uflow_strobes", npop, 0);
    chk("uflow_err", {31'd0, err}, 32'd1);
    chk("uflow_count", {27'd0, count}, 32'd0);
    chk("uflow_rxry", {24'd0, rx, ry}, 32'h10);

    // Fill to DEPTH with (i, 15-i), then overflow.
    for (int i = 0; i < DEPTH; i++) txn(i % 2, 1'b0, 4'(i), 4'(15 - i));
    chk("fill_count", {27'd0, count}, 32'd16);
    chk("fill_full", {30'd0, full, empty}, 32'd2);
    txn(0, 1'b0, 4'hF, 4'hF);
    chk("oflow_latency", lat, 3);
    chk("oflow_strobes", npush, 0);
    chk("oflow_err", {31'd0, err}, 32'd1);
    chk("oflow_count", {27'd0, count}, 32'd16);
    txn(1, 1'b1, 4'd0, 4'd0);
    chk("oflow_pop_rxry", {24'd0, rx, ry}, 32'hF0);
    chk("oflow_pop_err", {31'd0, err}, 32'd0);
    for (int i = DEPTH - 2; i >= 0; i--) begin
      txn(0, 1'b1, 4'd0, 4'd0);
      chk("drain_rxry", {24'd0, rx, ry}, {24'd0, 4'(i), 4'(15 - i)});
    end
    chk("drain_empty", {26'd0, count, empty}, 32'd1);

    // Unexpected stack failure: err and count held.
    fail_inject = 1'b1;
    txn(0, 1'b0, 4'd7, 4'd7);
    fail_inject = 1'b0;
    chk("sfail_err", {31'd0, err}, 32'd1);
    chk("sfail_count", {27'd0, count}, 32'd0);

    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;

    // Both pushing continuously: expect 0,1,0,1 with 3-cycle ack spacing.
    @(negedge clk);
    op = 2'b00;
    wx = {4'd5, 4'd3};
    wy = {4'd6, 4'd4};
    req = 2'b11;
    n = 0; cyc = 0;
    for (int i = 0; i < 40 && n < 4; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (ack != 2'b00) begin
        ack_idx[n] = ack[1] ? 1 : 0;
        ack_cyc[n] = cyc;
        n++;
        if (n == 4) req = 2'b00;
      end
    end
    req = 2'b00;
    chk("alt_acks", n, 4);
    if (n == 4) begin
      chk("alt_order", {28'd0, 4'(ack_idx[0]), 4'(ack_idx[1]), 4'(ack_idx[2]), 4'(ack_idx[3])}, 32'h0101);
      chk("alt_first_latency", ack_cyc[0], 3);
      chk("alt_spacing", {ack_cyc[1] - ack_cyc[0], ack_cyc[2] - ack_cyc[1], ack_cyc[3] - ack_cyc[2]} == {32'd3, 32'd3, 32'd3}, 32'd1);
    end
    chk("alt_count", {27'd0, count}, 32'd4);
    txn(0, 1'b1, 4'd0, 4'd0);
    chk("alt_pop_rxry", {24'd0, rx, ry}, 32'h56);
    txn(0, 1'b1, 4'd0, 4'd0);
    chk("alt_pop2_rxry", {24'd0, rx, ry}, 32'h34);

    // Reset asserted while in ISSUE.
    @(negedge clk);
    while (ack != 2'b00) @(negedge clk);
    op[0] = 1'b0; wx[3:0] = 4'd9; wy[3:0] = 4'd9; req[0] = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_strobe", {31'd0, stk_push}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_strobes", {22'd0, stk_push, stk_pop, stk_x, stk_y}, 32'd0);
    chk("mid_rst_count", {26'd0, count, empty}, 32'd1);
    chk("mid_rst_ack_err", {29'd0, ack, err}, 32'd0);
    chk("mid_rst_rxry", {24'd0, rx, ry}, 32'd0);
    req[0] = 1'b0;
    ack_cnt = 0;
    repeat (2) begin @(posedge clk); #1; if (ack != 2'b00) ack_cnt++; end
    @(negedge clk); rst = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (ack != 2'b00) ack_cnt++; end
    chk("mid_rst_no_ack", ack_cnt, 0);

    @(negedge clk);
    req = 2'b11;
    n = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (ack != 2'b00) begin n = ack[1] ? 1 : 0; break; end
    end
    req = 2'b00;
    chk("post_rst_first_grant", n, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
